asteroid_wave_controller: RTL and testbench

//  Sequences the asteroid special stage: intro delay, staggered per-slot release of the

---
 rtl/asteroid_wave_controller.sv | 197 +++++++++++++++++++
 tb/tb_asteroid_wave_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/asteroid_wave_controller.sv
// asteroid_wave_controller
//   Sequences the asteroid special stage. It runs an intro delay, then releases the asteroid
//   slots one at a time. It tracks hits on released slots, enforces the time limit, and
//   produces the clear/fail verdict.
// Ports:
//   clk, resetN      clock and asynchronous active-low reset
//   start            pulse: begin or restart the stage (honoured only when idle or finished)
//   startOfFrame     pulse once per video frame; all timing is counted in frames
//   asteroid_hit     per-slot hit level from the field
//   asteroid_enable  per-slot release mask to the field
//   stage_enable     gates the field's frame pulse (high while the stage is live)
//   hit_pulse        one-cycle pulse when any new hit is counted
//   hits_count       hits counted since the last start
//   frames_left      remaining time-limit frames
//   stage_cleared    level: stage won
//   stage_failed     level: time limit expired
module asteroid_wave_controller #(
  parameter int unsigned ASTEROIDS_AMOUNT  = 4,
  parameter int unsigned INTRO_FRAMES      = 60,
  parameter int unsigned SPAWN_INTERVAL    = 30,
  parameter int unsigned TIME_LIMIT_FRAMES = 1800,
  parameter int unsigned CLEAR_HOLD_FRAMES = 10,
  parameter int unsigned FRAME_CNT_WIDTH   = 11
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        start,
  input  logic                        startOfFrame,
  input  logic [ASTEROIDS_AMOUNT-1:0] asteroid_hit,
  output logic [ASTEROIDS_AMOUNT-1:0] asteroid_enable,
  output logic                        stage_enable,
  output logic                        hit_pulse,
  output logic [3:0]                  hits_count,
  output logic [FRAME_CNT_WIDTH-1:0]  frames_left,
  output logic                        stage_cleared,
  output logic                        stage_failed
);

  localparam int unsigned FW = FRAME_CNT_WIDTH;
  localparam logic [FW-1:0] IntroLoad = FW'(INTRO_FRAMES - 1);
  localparam logic [FW-1:0] SpawnLoad = FW'(SPAWN_INTERVAL - 1);
  localparam logic [FW-1:0] HoldLoad  = FW'(CLEAR_HOLD_FRAMES - 1);
  localparam logic [FW-1:0] TimeLoad  = FW'(TIME_LIMIT_FRAMES);
  localparam logic [FW-1:0] FwOne     = FW'(1);
  localparam logic [3:0]    LastIdx   = 4'(ASTEROIDS_AMOUNT - 1);

  typedef enum logic [2:0] {
    StIdle, StIntro, StSpawn, StActive, StHold, StCleared, StFailed
  } state_e;

  state_e                      state_q, state_d;
  logic [FW-1:0]               cnt_q, cnt_d;
  logic [FW-1:0]               fl_q, fl_d;
  logic [3:0]                  idx_q, idx_d;
  logic [ASTEROIDS_AMOUNT-1:0] en_q, en_d;
  logic [ASTEROIDS_AMOUNT-1:0] latch_q, latch_d;
  logic [ASTEROIDS_AMOUNT-1:0] hit_prev_q;
  logic [3:0]                  hits_q, hits_d;
  logic                        pulse_q, pulse_d;
  logic                        stage_en_q, cleared_q, failed_q;

  logic [ASTEROIDS_AMOUNT-1:0] new_hits;
  logic [3:0]                  new_cnt;
  logic                        all_hit;
  logic                        timeout;
  logic                        restart;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fl_d    = fl_q;
    idx_d   = idx_q;
    en_d    = en_q;
    restart = 1'b0;

    // A hit counts only on a rising level of a released, not yet latched slot.
    new_hits = asteroid_hit & ~hit_prev_q & en_q & ~latch_q;
    new_cnt  = '0;
    for (int i = 0; i < ASTEROIDS_AMOUNT; i++) begin
      new_cnt = new_cnt + 4'(new_hits[i]);
    end
    latch_d = latch_q | new_hits;
    hits_d  = hits_q + new_cnt;
    pulse_d = |new_hits;

    all_hit = (&latch_d) && (&en_q);
    timeout = startOfFrame && (fl_q <= FwOne);

    unique case (state_q)
      StIdle, StCleared, StFailed: begin
        if (start) restart = 1'b1;
      end
      StIntro: begin
        if (startOfFrame) begin
          if (cnt_q == '0) begin
            en_d[0] = 1'b1;
            fl_d    = TimeLoad;
            if (ASTEROIDS_AMOUNT == 1) begin
              state_d = StActive;
            end else begin
              state_d = StSpawn;
              idx_d   = 4'd1;
              cnt_d   = SpawnLoad;
            end
          end else begin
            cnt_d = cnt_q - FwOne;
          end
        end
      end
      StSpawn, StActive: begin
        // Clear has priority over time-limit expiry on the same cycle.
        if (all_hit) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end else if (startOfFrame) begin
          if (fl_q != '0) fl_d = fl_q - FwOne;
          if (timeout) begin
            state_d = StFailed;
            en_d    = '0;
          end else if (state_q == StSpawn) begin
            if (cnt_q == '0) begin
              for (int i = 0; i < ASTEROIDS_AMOUNT; i++) begin
                if (idx_q == 4'(i)) en_d[i] = 1'b1;
              end
              if (idx_q == LastIdx) begin
                state_d = StActive;
              end else begin
                idx_d = idx_q + 4'd1;
                cnt_d = SpawnLoad;
              end
            end else begin
              cnt_d = cnt_q - FwOne;
            end
          end
        end
      end
      StHold: begin
        if (startOfFrame) begin
          if (cnt_q == '0) state_d = StCleared;
          else             cnt_d   = cnt_q - FwOne;
        end
      end
      default: state_d = StIdle;
    endcase

    // Restart wipes all per-stage bookkeeping; a coincident frame pulse is not counted.
    if (restart) begin
      state_d = StIntro;
      cnt_d   = IntroLoad;
      fl_d    = '0;
      idx_d   = '0;
      en_d    = '0;
      latch_d = '0;
      hits_d  = '0;
      pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      fl_q       <= '0;
      idx_q      <= '0;
      en_q       <= '0;
      latch_q    <= '0;
      hit_prev_q <= '0;
      hits_q     <= '0;
      pulse_q    <= 1'b0;
      stage_en_q <= 1'b0;
      cleared_q  <= 1'b0;
      failed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fl_q       <= fl_d;
      idx_q      <= idx_d;
      en_q       <= en_d;
      latch_q    <= latch_d;
      hit_prev_q <= asteroid_hit;
      hits_q     <= hits_d;
      pulse_q    <= pulse_d;
      stage_en_q <= (state_d == StSpawn) || (state_d == StActive) || (state_d == StHold);
      cleared_q  <= (state_d == StCleared);
      failed_q   <= (state_d == StFailed);
    end
  end

  assign asteroid_enable = en_q;
  assign stage_enable    = stage_en_q;
  assign hit_pulse       = pulse_q;
  assign hits_count      = hits_q;
  assign frames_left     = fl_q;
  assign stage_cleared   = cleared_q;
  assign stage_failed    = failed_q;

endmodule

// File: tb/tb_asteroid_wave_controller.sv
module tb_asteroid_wave_controller;

  localparam int N     = 4;
  localparam int INTRO = 2;
  localparam int SPAWN = 3;
  localparam int TLIM  = 20;
  localparam int HOLD  = 2;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic        startOfFrame;
  logic [3:0]  asteroid_hit;
  logic [3:0]  asteroid_enable;
  logic        stage_enable;
  logic        hit_pulse;
  logic [3:0]  hits_count;
  logic [10:0] frames_left;
  logic        stage_cleared;
  logic        stage_failed;

  int n_vec = 0;
  int n_err = 0;

  asteroid_wave_controller #(
    .ASTEROIDS_AMOUNT (N),
    .INTRO_FRAMES     (INTRO),
    .SPAWN_INTERVAL   (SPAWN),
    .TIME_LIMIT_FRAMES(TLIM),
    .CLEAR_HOLD_FRAMES(HOLD),
    .FRAME_CNT_WIDTH  (11)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .start          (start),
    .startOfFrame   (startOfFrame),
    .asteroid_hit   (asteroid_hit),
    .asteroid_enable(asteroid_enable),
    .stage_enable   (stage_enable),
    .hit_pulse      (hit_pulse),
    .hits_count     (hits_count),
    .frames_left    (frames_left),
    .stage_cleared  (stage_cleared),
    .stage_failed   (stage_failed)
  );

  always #5 clk = ~clk;

  // Reference model: the stage is described by frames counted since start (m_f), and a
  // verdict (0 live, 1 holding, 2 cleared, 3 failed). Release mask and remaining time are
  // arithmetic functions of m_f.
  bit         m_run;
  int         m_verdict;
  int         m_f;
  int         m_hold;
  logic [3:0] m_latch;
  int         m_hits;
  bit         m_pulse;
  logic [3:0] m_prev;

  function automatic int released();
    int r;
    if (!m_run || m_f < INTRO) return 0;
    r = 1 + (m_f - INTRO) / SPAWN;
    return (r > N) ? N : r;
  endfunction

  function automatic logic [3:0] exp_mask();
    int m;
    if (!m_run || m_verdict == 3) return 4'h0;
    m = (1 << released()) - 1;
    return m[3:0];
  endfunction

  function automatic int exp_fl();
    if (!m_run || m_f < INTRO) return 0;
    return TLIM - (m_f - INTRO);
  endfunction

  function automatic bit exp_stage_en();
    return m_run && (m_f >= INTRO) && (m_verdict <= 1);
  endfunction

  task automatic model_reset();
    m_run = 0; m_verdict = 0; m_f = 0; m_hold = 0;
    m_latch = 4'h0; m_hits = 0; m_pulse = 0; m_prev = 4'h0;
  endtask

  task automatic model_step(input bit st, input bit sof, input logic [3:0] hit);
    logic [3:0] nw;
    nw = hit & ~m_prev & exp_mask() & ~m_latch;
    m_prev = hit;
    if (!m_run || m_verdict >= 2) begin
      m_pulse = 0;
      if (st) begin
        m_run = 1; m_f = 0; m_verdict = 0; m_latch = 4'h0; m_hits = 0;
      end
      return;
    end
    m_latch = m_latch | nw;
    m_hits  = m_hits + $countones(nw);
    m_pulse = (nw != 4'h0);
    if (m_verdict == 0) begin
      if (m_f >= INTRO && released() == N && m_latch == 4'hF) begin
        m_verdict = 1;
        m_hold    = HOLD;
      end else if (sof) begin
        m_f++;
        if (m_f >= INTRO && exp_fl() == 0) m_verdict = 3;
      end
    end else if (sof) begin
      m_hold--;
      if (m_hold == 0) m_verdict = 2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compare_all();
    chk("asteroid_enable", 32'(asteroid_enable), 32'(exp_mask()));
    chk("stage_enable",    32'(stage_enable),    32'(exp_stage_en()));
    chk("hit_pulse",       32'(hit_pulse),       32'(m_pulse));
    chk("hits_count",      32'(hits_count),      32'(m_hits));
    chk("frames_left",     32'(frames_left),     32'(exp_fl()));
    chk("stage_cleared",   32'(stage_cleared),   32'(m_verdict == 2));
    chk("stage_failed",    32'(stage_failed),    32'(m_verdict == 3));
  endtask

  task automatic step(input bit st, input bit sof, input logic [3:0] hit);
    start = st; startOfFrame = sof; asteroid_hit = hit;
    @(posedge clk);
    model_step(st, sof, hit);
    #1;
    compare_all();
  endtask

  task automatic frames(input int n, input logic [3:0] hit);
    repeat (n) begin
      step(1'b0, 1'b1, hit);
      step(1'b0, 1'b0, hit);
    end
  endtask

  task automatic async_reset();
    #3;
    resetN = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    resetN = 1'b1;
  endtask

  initial begin
    logic [3:0] h;
    resetN = 1'b0; start = 1'b0; startOfFrame = 1'b0; asteroid_hit = 4'h0;
    model_reset();
    #12;
    compare_all();
    chk("reset_frames_left", 32'(frames_left), 32'd0);
    resetN = 1'b1;
    step(0, 0, 4'h0);

    // Intro and staggered release
    step(1, 0, 4'h0);
    frames(INTRO, 4'h0);
    chk("intro_mask", 32'(asteroid_enable), 32'h1);
    chk("intro_frames_left", 32'(frames_left), 32'd20);
    frames(3 * SPAWN, 4'h0);
    chk("full_mask", 32'(asteroid_enable), 32'hF);

    // Hits one frame apart, then hold and clear
    h = 4'h0;
    for (int i = 0; i < N; i++) begin
      h[i] = 1'b1;
      step(0, 1, h);
      step(0, 0, h);
    end
    chk("four_hits", 32'(hits_count), 32'd4);
    frames(HOLD, h);
    chk("cleared", 32'(stage_cleared), 32'd1);
    chk("cleared_stage_en", 32'(stage_enable), 32'd0);

    // Hit on an unreleased slot never counts; stage then times out
    step(0, 0, 4'h0);
    step(1, 0, 4'h0);
    step(0, 1, 4'h8);
    step(0, 0, 4'h8);
    frames(INTRO - 1, 4'h8);
    chk("masked_hit_mask", 32'(asteroid_enable), 32'h1);
    chk("masked_hit_count", 32'(hits_count), 32'd0);
    frames(3 * SPAWN, 4'h8);
    chk("masked_hit_released", 32'(hits_count), 32'd0);
    frames(TLIM - 3 * SPAWN, 4'h8);
    chk("timeout_failed", 32'(stage_failed), 32'd1);
    chk("timeout_mask", 32'(asteroid_enable), 32'h0);
    chk("timeout_fl", 32'(frames_left), 32'd0);

    // Final hit coincides with the expiring frame: clear wins
    step(1, 0, 4'h0);
    frames(INTRO + 3 * SPAWN, 4'h0);
    step(0, 0, 4'h7);
    while (exp_fl() > 1) step(0, 1, 4'h7);
    step(0, 1, 4'hF);
    chk("race_not_failed", 32'(stage_failed), 32'd0);
    chk("race_hold", 32'(stage_enable), 32'd1);
    chk("race_hits", 32'(hits_count), 32'd4);
    frames(HOLD, 4'hF);

    // Two slots hit on the same cycle
    step(0, 0, 4'h0);
    step(1, 0, 4'h0);
    frames(INTRO + 3 * SPAWN, 4'h0);
    step(0, 0, 4'h6);
    chk("dual_pulse", 32'(hit_pulse), 32'd1);
    chk("dual_count", 32'(hits_count), 32'd2);
    step(0, 0, 4'h6);
    chk("dual_pulse_end", 32'(hit_pulse), 32'd0);

    // Asynchronous reset mid-SPAWN, then restart from FAILED
    async_reset();
    step(1, 0, 4'h0);
    frames(INTRO + 1, 4'h0);
    async_reset();
    chk("rst_mask", 32'(asteroid_enable), 32'h0);
    chk("rst_stage_en", 32'(stage_enable), 32'd0);
    step(1, 1, 4'h0);
    frames(INTRO + TLIM, 4'h0);
    chk("fail_again", 32'(stage_failed), 32'd1);
    step(1, 0, 4'h0);
    chk("restart_failed", 32'(stage_failed), 32'd0);
    chk("restart_hits", 32'(hits_count), 32'd0);
    chk("restart_fl", 32'(frames_left), 32'd0);

    // Randomized traffic
    h = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      bit st, sof;
      st  = ($urandom_range(0, 99) < 3);
      sof = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 15) == 0) h[b] = ~h[b];
      end
      if ($urandom_range(0, 599) == 0) async_reset();
      else step(st, sof, h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
